// File: rtl/cam_capture_scaled_pkg.sv
// rtl/cam_capture_scaled_pkg.sv - shared types and constants for the camera capture path
// Package cam_pkg: FSM state encoding, RGB565 field widths, frame-buffer
// format selectors and the RGB565 colour-bar table.
// Optional feature macro: CAM_TEST_PATTERN_EN (bar table used only then).
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_VS_HIGH = 2'd0,
    WAIT_VS_LOW  = 2'd1,
    CAPTURE      = 2'd2
  } cam_state_e;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  localparam int FMT_RGB332 = 8;
  localparam int FMT_RGB444 = 12;
  localparam int FMT_RGB565 = 16;

  // Vertical colour bars, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;  // white
      3'd1:    bar_color = 16'hFFE0;  // yellow
      3'd2:    bar_color = 16'h07FF;  // cyan
      3'd3:    bar_color = 16'h07E0;  // green
      3'd4:    bar_color = 16'hF81F;  // magenta
      3'd5:    bar_color = 16'hF800;  // red
      3'd6:    bar_color = 16'h001F;  // blue
      default: bar_color = 16'h0000;  // black
    endcase
  endfunction

endpackage

// File: rtl/cam_capture_scaled_if.sv
// rtl/cam_capture_scaled_if.sv - frame-buffer write port interface
// Signals: wr_en (1-cycle strobe), wr_addr [ADDR_W], wr_data [PIX_W].
// Modports: master drives the write port, slave receives it.
interface cam_capture_scaled_if #(
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/cam_capture_scaled_pix_fmt.sv
// rtl/cam_capture_scaled_pix_fmt.sv - combinational RGB565 to frame-buffer pixel converter
// Ports: rgb565_i [16] in, pix_o [PIX_W] out.
// PIX_W = 8 -> RGB332, 12 -> RGB444, 16 -> passthrough; other widths fail elaboration.
module cam_pix_fmt
  import cam_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [15:0]      rgb565_i,
  output logic [PIX_W-1:0] pix_o
);

  logic [R_W-1:0] r;
  logic [G_W-1:0] g;
  logic [B_W-1:0] b;

  assign {r, g, b} = rgb565_i;

  generate
    if (PIX_W == FMT_RGB332) begin : g_rgb332
      logic unused_bits;
      assign unused_bits = ^{r[1:0], g[2:0], b[2:0]};
      assign pix_o = {r[4:2], g[5:3], b[4:3]};
    end else if (PIX_W == FMT_RGB444) begin : g_rgb444
      logic unused_bits;
      assign unused_bits = ^{r[0], g[1:0], b[0]};
      assign pix_o = {r[4:1], g[5:2], b[4:1]};
    end else if (PIX_W == FMT_RGB565) begin : g_rgb565
      assign pix_o = {r, g, b};
    end else begin : g_bad_width
      $error("cam_pix_fmt: PIX_W must be 8, 12 or 16");
      assign pix_o = '0;
    end
  endgenerate

endmodule

// File: rtl/cam_capture_scaled.sv
// rtl/cam_capture_scaled.sv - OV7670 capture with decimation and frame-buffer writes
// Ports: clk, rst (async, active high); cam_pclk/cam_vsync/cam_href/cam_d camera
// pins (asynchronous); test_mode; fb (write-port master: wr_en/wr_addr/wr_data);
// frame_done pulse, frame_count [8], overflow (sticky per frame).
// Optional feature macro: CAM_TEST_PATTERN_EN replaces kept pixels with colour
// bars when test_mode = 1.
module cam_capture_scaled
  import cam_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 15,
  parameter int FB_DEPTH = 19200,
  parameter int H_DEC    = 4,
  parameter int V_DEC    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cam_pclk,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [7:0]           cam_d,
  input  logic                 test_mode,
  cam_capture_scaled_if.master fb,
  output logic                 frame_done,
  output logic [7:0]           frame_count,
  output logic                 overflow
);

  generate
    if (FB_DEPTH < 1 || FB_DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("cam_capture_scaled: FB_DEPTH must be 1..2**ADDR_W");
    end
    if (H_DEC < 1 || H_DEC > 16) begin : g_bad_hdec
      $error("cam_capture_scaled: H_DEC must be 1..16");
    end
    if (V_DEC < 1 || V_DEC > 16) begin : g_bad_vdec
      $error("cam_capture_scaled: V_DEC must be 1..16");
    end
  endgenerate

  // One extra address bit so the counter can rest at FB_DEPTH even when
  // FB_DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(FB_DEPTH);
  localparam logic [3:0]      H_MAX = 4'(H_DEC - 1);
  localparam logic [3:0]      V_MAX = 4'(V_DEC - 1);

  // Synchronisers; pclk has a third stage for edge detection.
  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       vs_s1_q, vs_s2_q;
  logic       href_s1_q, href_s2_q;
  logic [7:0] d_s1_q, d_s2_q;
  logic       pclk_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1_q <= 1'b0; pclk_s2_q <= 1'b0; pclk_s3_q <= 1'b0;
      vs_s1_q   <= 1'b0; vs_s2_q   <= 1'b0;
      href_s1_q <= 1'b0; href_s2_q <= 1'b0;
      d_s1_q    <= 8'd0; d_s2_q    <= 8'd0;
    end else begin
      pclk_s1_q <= cam_pclk;  pclk_s2_q <= pclk_s1_q; pclk_s3_q <= pclk_s2_q;
      vs_s1_q   <= cam_vsync; vs_s2_q   <= vs_s1_q;
      href_s1_q <= cam_href;  href_s2_q <= href_s1_q;
      d_s1_q    <= cam_d;     d_s2_q    <= d_s1_q;
    end
  end

  assign pclk_edge = pclk_s2_q & ~pclk_s3_q;

  // FSM: state register.
  cam_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_VS_HIGH;
    else     state_q <= state_d;
  end

  // FSM: next state, only ever on a pclk edge.
  always_comb begin
    state_d = state_q;
    if (pclk_edge) begin
      case (state_q)
        WAIT_VS_HIGH: if (vs_s2_q)  state_d = WAIT_VS_LOW;
        WAIT_VS_LOW:  if (!vs_s2_q) state_d = CAPTURE;
        CAPTURE:      if (vs_s2_q)  state_d = WAIT_VS_LOW;
        default:                    state_d = WAIT_VS_HIGH;
      endcase
    end
  end

  // FSM: decoded events for the datapath.
  logic frame_start, frame_end, cap_edge;

  always_comb begin
    frame_start = 1'b0;
    frame_end   = 1'b0;
    cap_edge    = 1'b0;
    if (pclk_edge) begin
      case (state_q)
        WAIT_VS_LOW: frame_start = !vs_s2_q;
        CAPTURE: begin
          frame_end = vs_s2_q;
          cap_edge  = !vs_s2_q;
        end
        default: ;
      endcase
    end
  end

  // Datapath state.
  logic              phase_q;
  logic [7:0]        hi_q;
  logic [3:0]        xm_q, ym_q;
  logic              line_pix_q;
  logic              href_prev_q;
  logic [ADDR_W:0]   wr_addr_q;
  logic              wr_en_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic              frame_done_q;
  logic [7:0]        frame_count_q;
  logic              overflow_q;
  logic              keep;
  logic [15:0]       rgb565;
  logic [PIX_W-1:0]  pix_conv;

  assign keep = (xm_q == 4'd0) && (ym_q == 4'd0);

`ifdef CAM_TEST_PATTERN_EN
  // Count of horizontally kept pixels on this line; bits [6:4] pick the bar.
  logic [6:0] kx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx_q <= 7'd0;
    end else if (frame_start) begin
      kx_q <= 7'd0;
    end else if (cap_edge) begin
      if (href_s2_q && phase_q && xm_q == 4'd0) kx_q <= kx_q + 7'd1;
      else if (!href_s2_q && href_prev_q)       kx_q <= 7'd0;
    end
  end

  assign rgb565 = test_mode ? bar_color(kx_q[6:4]) : {hi_q, d_s2_q};
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign rgb565 = {hi_q, d_s2_q};
`endif

  cam_pix_fmt #(.PIX_W(PIX_W)) u_pix_fmt (
    .rgb565_i (rgb565),
    .pix_o    (pix_conv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= 1'b0;
      hi_q          <= 8'd0;
      xm_q          <= 4'd0;
      ym_q          <= 4'd0;
      line_pix_q    <= 1'b0;
      href_prev_q   <= 1'b0;
      wr_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
      overflow_q    <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;

      // Advance after the strobe so wr_addr shows the written location.
      if (wr_en_q && wr_addr_q != DEPTH)
        wr_addr_q <= wr_addr_q + {{ADDR_W{1'b0}}, 1'b1};

      if (frame_start) begin
        phase_q     <= 1'b0;
        xm_q        <= 4'd0;
        ym_q        <= 4'd0;
        line_pix_q  <= 1'b0;
        href_prev_q <= 1'b0;
        wr_addr_q   <= '0;
        overflow_q  <= 1'b0;
      end

      // Partial pixel is simply abandoned; the next frame start clears it.
      if (frame_end) begin
        frame_done_q  <= 1'b1;
        frame_count_q <= frame_count_q + 8'd1;
        phase_q       <= 1'b0;
      end

      if (cap_edge) begin
        href_prev_q <= href_s2_q;
        if (href_s2_q) begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            hi_q <= d_s2_q;
          end else begin
            line_pix_q <= 1'b1;
            xm_q       <= (xm_q == H_MAX) ? 4'd0 : xm_q + 4'd1;
            if (keep) begin
              if (wr_addr_q < DEPTH) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= pix_conv;
              end else begin
                overflow_q <= 1'b1;
              end
            end
          end
        end else begin
          phase_q <= 1'b0;
          if (href_prev_q) begin
            xm_q       <= 4'd0;
            line_pix_q <= 1'b0;
            if (line_pix_q) ym_q <= (ym_q == V_MAX) ? 4'd0 : ym_q + 4'd1;
          end
        end
      end
    end
  end

  assign fb.wr_en     = wr_en_q;
  assign fb.wr_addr   = wr_addr_q[ADDR_W-1:0];
  assign fb.wr_data   = wr_data_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_cam_capture_scaled.sv
// tb/tb_cam_capture_scaled.sv - self-checking bench for cam_capture_scaled
module tb_cam_capture_scaled;

  typedef logic [22:0] ent_t;  // {addr[14:0], data[7:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cam_pclk = 1'b0;
  logic       cam_vsync = 1'b0;
  logic       cam_href = 1'b0;
  logic [7:0] cam_d = 8'd0;
  logic       tm = 1'b0;

  logic       fd_a, fd_b, fd_c, ovf_a, ovf_b, ovf_c;
  logic [7:0] fc_a, fc_b, fc_c;

  cam_capture_scaled_if #(.ADDR_W(15), .PIX_W(8)) fb_a ();
  cam_capture_scaled_if #(.ADDR_W(15), .PIX_W(8)) fb_b ();
  cam_capture_scaled_if #(.ADDR_W(15), .PIX_W(8)) fb_c ();

  cam_capture_scaled #(.PIX_W(8), .ADDR_W(15), .FB_DEPTH(19200), .H_DEC(1), .V_DEC(1)) dut_a (
    .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_d(cam_d), .test_mode(tm), .fb(fb_a), .frame_done(fd_a), .frame_count(fc_a), .overflow(ovf_a));

  cam_capture_scaled #(.PIX_W(8), .ADDR_W(15), .FB_DEPTH(19200), .H_DEC(4), .V_DEC(2)) dut_b (
    .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_d(cam_d), .test_mode(tm), .fb(fb_b), .frame_done(fd_b), .frame_count(fc_b), .overflow(ovf_b));

  cam_capture_scaled #(.PIX_W(8), .ADDR_W(15), .FB_DEPTH(10), .H_DEC(1), .V_DEC(1)) dut_c (
    .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_d(cam_d), .test_mode(tm), .fb(fb_c), .frame_done(fd_c), .frame_count(fc_c), .overflow(ovf_c));

  always #5 clk = ~clk;

  int asserts = 0;
  int fails = 0;

  ent_t q0[$], q1[$], q2[$];
  int   wr_cnt[3] = '{0, 0, 0};
  int   fd_cnt = 0;

  // Reference model state (x/y/phase shared; decimation and depth per DUT).
  int         m_h[3] = '{1, 4, 1};
  int         m_v[3] = '{1, 2, 1};
  int         m_d[3] = '{19200, 19200, 10};
  int         m_addr[3] = '{0, 0, 0};
  bit         m_ovf[3] = '{0, 0, 0};
  int         m_x = 0;
  int         m_y = 0;
  bit         m_phase = 0;
  bit         m_live = 0;
  logic [7:0] m_hi = 8'd0;
  logic [7:0] exp_fc = 8'd0;
  int         exp_fd = 0;

  // Scoreboard monitors.
  always @(negedge clk) begin
    ent_t e;
    if (fb_a.wr_en === 1'b1) begin
      wr_cnt[0]++; asserts++;
      if (q0.size() == 0) begin
        fails++; $display("FAIL sb_a: unexpected write addr=%0d data=%h", fb_a.wr_addr, fb_a.wr_data);
      end else begin
        e = q0.pop_front();
        if ({fb_a.wr_addr, fb_a.wr_data} !== e) begin
          fails++; $display("FAIL sb_a: got addr=%0d data=%h expected addr=%0d data=%h",
                            fb_a.wr_addr, fb_a.wr_data, e[22:8], e[7:0]);
        end
      end
    end
    if (fd_a === 1'b1) fd_cnt++;
  end

  always @(negedge clk) begin
    ent_t e;
    if (fb_b.wr_en === 1'b1) begin
      wr_cnt[1]++; asserts++;
      if (q1.size() == 0) begin
        fails++; $display("FAIL sb_b: unexpected write addr=%0d data=%h", fb_b.wr_addr, fb_b.wr_data);
      end else begin
        e = q1.pop_front();
        if ({fb_b.wr_addr, fb_b.wr_data} !== e) begin
          fails++; $display("FAIL sb_b: got addr=%0d data=%h expected addr=%0d data=%h",
                            fb_b.wr_addr, fb_b.wr_data, e[22:8], e[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (fb_c.wr_en === 1'b1) begin
      wr_cnt[2]++; asserts++;
      if (q2.size() == 0) begin
        fails++; $display("FAIL sb_c: unexpected write addr=%0d data=%h", fb_c.wr_addr, fb_c.wr_data);
      end else begin
        e = q2.pop_front();
        if ({fb_c.wr_addr, fb_c.wr_data} !== e) begin
          fails++; $display("FAIL sb_c: got addr=%0d data=%h expected addr=%0d data=%h",
                            fb_c.wr_addr, fb_c.wr_data, e[22:8], e[7:0]);
        end
      end
    end
  end

  function automatic logic [15:0] bar565(input int idx);
    case (idx)
      0: return 16'hFFFF; 1: return 16'hFFE0; 2: return 16'h07FF; 3: return 16'h07E0;
      4: return 16'hF81F; 5: return 16'hF800; 6: return 16'h001F; default: return 16'h0000;
    endcase
  endfunction

  task automatic pclk_cycle();
    cam_pclk = 1'b0; #40;
    cam_pclk = 1'b1; #40;
  endtask

  // Drive one byte with href high and update the reference model.
  task automatic cam_byte(input logic [7:0] b);
    logic [15:0] rgb;
    logic [7:0]  pix;
    ent_t        e;
    cam_d = b; cam_href = 1'b1;
    if (m_live && !cam_vsync) begin
      if (!m_phase) begin
        m_hi = b; m_phase = 1;
      end else begin
        m_phase = 0;
        for (int k = 0; k < 3; k++) begin
          if ((m_x % m_h[k]) == 0 && (m_y % m_v[k]) == 0) begin
            if (m_addr[k] < m_d[k]) begin
              rgb = {m_hi, b};
`ifdef CAM_TEST_PATTERN_EN
              if (tm) rgb = bar565(((m_x / m_h[k]) >> 4) & 7);
`endif
              pix = {rgb[15:13], rgb[10:8], rgb[4:3]};
              e = {15'(m_addr[k]), pix};
              if (k == 0) q0.push_back(e);
              else if (k == 1) q1.push_back(e);
              else q2.push_back(e);
              m_addr[k]++;
            end else begin
              m_ovf[k] = 1;
            end
          end
        end
        m_x++;
      end
    end
    pclk_cycle();
  endtask

  task automatic line_end();
    cam_href = 1'b0;
    if (m_live) begin
      m_phase = 0;
      if (m_x > 0) m_y++;
      m_x = 0;
    end
    pclk_cycle();
    pclk_cycle();
  endtask

  // Raise vsync for one pclk; ends a frame in progress. Leaves href as is.
  task automatic frame_end();
    cam_vsync = 1'b1;
    if (m_live) begin
      exp_fc = exp_fc + 8'd1;
      exp_fd++;
    end
    m_live = 0; m_phase = 0; m_x = 0;
    pclk_cycle();
  endtask

  task automatic frame_begin();
    cam_href = 1'b0;
    frame_end();
    cam_vsync = 1'b0;
    pclk_cycle();
    m_live = 1; m_y = 0; m_x = 0; m_phase = 0;
    for (int k = 0; k < 3; k++) begin m_addr[k] = 0; m_ovf[k] = 0; end
  endtask

  task automatic test_reset();
    #25;
    asserts++;
    if ({fb_a.wr_en, fb_a.wr_addr, fb_a.wr_data, fd_a, fc_a, ovf_a} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0",
                        {fb_a.wr_en, fb_a.wr_addr, fb_a.wr_data, fd_a, fc_a, ovf_a});
    end
    @(negedge clk); rst = 1'b0;
    // vsync low without a preceding high: must not start capture.
    cam_byte(8'h55); cam_byte(8'hAA); line_end();
    asserts++;
    if (wr_cnt[0] != 0) begin
      fails++; $display("FAIL reset_no_capture: writes=%0d required 0", wr_cnt[0]);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    int c0;
    c0 = wr_cnt[0];
    frame_begin();
    foreach (bytes[i]) cam_byte(bytes[i]);
    line_end();
    asserts++;
    if (wr_cnt[0] - c0 != 4) begin
      fails++; $display("FAIL basic_count: writes=%0d required 4", wr_cnt[0] - c0);
    end
    asserts++;
    if (fb_a.wr_data !== 8'hFF || fb_a.wr_addr !== 15'd4) begin
      fails++; $display("FAIL basic_last: data=%h addr=%0d required FF 4", fb_a.wr_data, fb_a.wr_addr);
    end
  endtask

  task automatic test_decimation();
    int c1;
    c1 = wr_cnt[1];
    frame_begin();
    for (int ln = 0; ln < 4; ln++) begin
      for (int p = 0; p < 640; p++) begin
        cam_byte(8'($urandom));
        cam_byte(8'($urandom));
      end
      line_end();
    end
    asserts++;
    if (wr_cnt[1] - c1 != 320) begin
      fails++; $display("FAIL dec_count: writes=%0d required 320", wr_cnt[1] - c1);
    end
    asserts++;
    if (fb_b.wr_addr !== 15'd320) begin
      fails++; $display("FAIL dec_addr: addr=%0d required 320", fb_b.wr_addr);
    end
  endtask

  task automatic test_overflow();
    int c2;
    frame_begin();
    c2 = wr_cnt[2];
    for (int p = 0; p < 16; p++) begin
      cam_byte(8'(p * 16)); cam_byte(8'(p));
    end
    line_end();
    asserts++;
    if (wr_cnt[2] - c2 != 10) begin
      fails++; $display("FAIL ovf_count: writes=%0d required 10", wr_cnt[2] - c2);
    end
    asserts++;
    if (ovf_c !== 1'b1 || ovf_a !== 1'b0) begin
      fails++; $display("FAIL ovf_set: ovf_c=%b ovf_a=%b required 1 0", ovf_c, ovf_a);
    end
    asserts++;
    if (fb_c.wr_addr !== 15'd10) begin
      fails++; $display("FAIL ovf_addr: addr=%0d required 10", fb_c.wr_addr);
    end
    frame_begin();
    asserts++;
    if (ovf_c !== 1'b0) begin
      fails++; $display("FAIL ovf_clear: ovf_c=%b required 0", ovf_c);
    end
  endtask

  task automatic test_vsync_midline();
    int c0, f0;
    logic [7:0] fc0;
    frame_begin();
    c0 = wr_cnt[0]; f0 = fd_cnt; fc0 = fc_a;
    cam_byte(8'hF8); cam_byte(8'h00); cam_byte(8'h07);
    cam_d = 8'hE0;
    frame_end();
    cam_href = 1'b0;
    pclk_cycle();
    asserts++;
    if (wr_cnt[0] - c0 != 1) begin
      fails++; $display("FAIL midline_writes: writes=%0d required 1", wr_cnt[0] - c0);
    end
    asserts++;
    if (fd_cnt - f0 != 1) begin
      fails++; $display("FAIL midline_done: pulses=%0d required 1", fd_cnt - f0);
    end
    asserts++;
    if (fc_a !== fc0 + 8'd1 || fc_a !== exp_fc) begin
      fails++; $display("FAIL midline_count: frame_count=%0d required %0d", fc_a, exp_fc);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 257; i++) begin
      frame_begin();
      asserts++;
      if (fc_a !== exp_fc || fc_b !== exp_fc || fc_c !== exp_fc) begin
        fails++; $display("FAIL wrap_count: frame_count=%0d/%0d/%0d required %0d", fc_a, fc_b, fc_c, exp_fc);
      end
    end
    asserts++;
    if (fd_cnt != exp_fd) begin
      fails++; $display("FAIL frame_done_total: pulses=%0d required %0d", fd_cnt, exp_fd);
    end
  endtask

  task automatic test_reset_midline();
    int c0;
    frame_begin();
    cam_byte(8'h12); cam_byte(8'h34); cam_byte(8'h56);
    #13;
    rst = 1'b1;
    #1;
    asserts++;
    if ({fb_a.wr_en, fb_a.wr_addr, fb_a.wr_data, fd_a, fc_a, ovf_a, ovf_c, fb_c.wr_data} !== '0) begin
      fails++; $display("FAIL rst_async: got %h required 0",
                        {fb_a.wr_en, fb_a.wr_addr, fb_a.wr_data, fd_a, fc_a, ovf_a, ovf_c, fb_c.wr_data});
    end
    m_live = 0; m_phase = 0; m_x = 0; exp_fc = 8'd0;
    cam_href = 1'b0;
    #20; @(negedge clk); rst = 1'b0;
    c0 = wr_cnt[0];
    cam_byte(8'h12); cam_byte(8'h34); line_end();
    asserts++;
    if (wr_cnt[0] != c0) begin
      fails++; $display("FAIL rst_no_write: writes=%0d required 0", wr_cnt[0] - c0);
    end
    frame_begin();
    tm = 1'b1;
    for (int p = 0; p < 4; p++) begin cam_byte(8'h12); cam_byte(8'h34); end
    line_end();
    tm = 1'b0;
    asserts++;
    if (wr_cnt[0] - c0 != 4) begin
      fails++; $display("FAIL rst_resume: writes=%0d required 4", wr_cnt[0] - c0);
    end
`ifdef CAM_TEST_PATTERN_EN
    asserts++;
    if (fb_a.wr_data !== 8'hFF) begin
      fails++; $display("FAIL pattern_white: data=%h required FF", fb_a.wr_data);
    end
`endif
    asserts++;
    if (fc_a !== 8'd0) begin
      fails++; $display("FAIL rst_count: frame_count=%0d required 0", fc_a);
    end
  endtask

  task automatic test_drain();
    asserts++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      fails++; $display("FAIL sb_drain: pending=%0d/%0d/%0d required 0", q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decimation();
    test_overflow();
    test_vsync_midline();
    test_wrap();
    test_reset_midline();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/cam_capture_scaled.md
Name: cam_capture_scaled

Overview:
Parametrised successor to the single-format camera capture path. Samples the OV7670 byte stream (pclk/href/vsync/d) in the system `clk` domain and pairs bytes into RGB565 pixels. Applies independent horizontal and vertical decimation, converts each pixel to the frame-buffer pixel width, and emits write strobes and linear addresses into the frame buffer. Sits between the camera pins and the dual-port frame buffer read by the VGA painter.

Parameters:
PIX_W, 8, frame-buffer pixel width: 8 = RGB332, 12 = RGB444, 16 = raw RGB565; any other value is a compile-time error.
ADDR_W, 15, frame-buffer address width.
FB_DEPTH, 19200, number of writable locations; must be <= 2**ADDR_W.
H_DEC, 4, horizontal keep-1-of-N factor; 1..16.
V_DEC, 4, vertical keep-1-of-N factor; 1..16.

Ports:
clk  in  1  system clock; must be >= 4x cam_pclk.
rst  in  1  asynchronous, active-high reset.
cam_pclk  in  1  camera pixel clock, asynchronous to clk.
cam_vsync  in  1  camera vsync; high = vertical blanking.
cam_href  in  1  camera line-valid.
cam_d  in  8  camera data byte.
test_mode  in  1  selects test pattern; used only with CAM_TEST_PATTERN_EN.
wr_en  out  1  one-cycle frame-buffer write strobe.
wr_addr  out  ADDR_W  write address.
wr_data  out  PIX_W  write pixel.
frame_done  out  1  one-cycle pulse when a captured frame ends.
frame_count  out  8  frames completed; wraps 255 -> 0.
overflow  out  1  sticky per frame: a kept pixel fell at address >= FB_DEPTH.

Behaviour:
- Reset: every output is 0, the FSM is in WAIT_VS_HIGH, and all counters are 0.
- Input sync: cam_pclk, cam_vsync, cam_href and cam_d each pass through a 2-flop synchroniser. A pclk rising edge is detected as sync2 & ~sync3.
  - All camera events are evaluated only on a pclk-edge cycle.
  - href and d are taken from the same synchronised stage as the edge.
- FSM:
  - WAIT_VS_HIGH -> WAIT_VS_LOW when vsync = 1. This discards any partial frame after reset.
  - WAIT_VS_LOW -> CAPTURE when vsync = 0. On this transition: clear the x/y/decimation counters, the byte phase, wr_addr and overflow.
  - CAPTURE -> WAIT_VS_LOW when vsync = 1. On this transition: frame_done pulses for 1 cycle and frame_count increments.
- Byte pairing in CAPTURE, on each pclk edge with href = 1:
  - phase 0 latches the high byte; phase 1 forms rgb565 = {hi, d}.
  - phase toggles every byte and clears when href = 0. A stray odd byte is therefore dropped at line end.
- Line tracking:
  - The x counter increments per completed pixel and clears on the href falling edge.
  - The y counter increments on the href falling edge, but only if the line contained at least 1 pixel.
- Decimation: a pixel is kept iff (x mod H_DEC == 0) and (y mod V_DEC == 0). Use wrapping modulo counters, not dividers.
- Format conversion, bit-select only:
  - 8 -> {r[4:2], g[5:3], b[4:3]}
  - 12 -> {r[4:1], g[5:2], b[4:1]}
  - 16 -> passthrough.
- Write timing: for a kept pixel, wr_en, wr_addr and wr_data are registered and asserted exactly 1 clk after the phase-1 edge cycle. wr_addr then increments, saturating at FB_DEPTH.
- Bound: if a kept pixel occurs when wr_addr == FB_DEPTH, wr_en stays 0 and overflow sets. It holds until the next CAPTURE entry.
- vsync rising mid-line: the frame ends immediately and the partial pixel is dropped; the frame_done pulse still fires.
- Reset asserted mid-frame: outputs clear asynchronously. After release the block must see vsync high, then low, before writing.
- Latency, pin to write: 2 sync cycles + 1 edge-detect cycle + 1 register cycle, plus the pclk phase.

Optional Feature:
Macro CAM_TEST_PATTERN_EN.
- Defined: when test_mode = 1, each kept pixel's wr_data is replaced by 8 vertical colour bars indexed by the decimated column (x_kept * 8 / (line width)). This is approximated by bits [6:4] of the kept-x counter.
  - Bar colours, index 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  - Timing, addresses and strobes are unchanged.
- Undefined: test_mode is ignored and no pattern logic is synthesised.

Decomposition:
- Shared package cam_pkg holds:
  - FSM state encoding: WAIT_VS_HIGH = 2'd0, WAIT_VS_LOW = 2'd1, CAPTURE = 2'd2.
  - RGB565 field widths.
  - The format-select constants 8/12/16.
  - The test-pattern colour table in RGB565.
- One natural sub-module: cam_pix_fmt, the combinational RGB565 -> PIX_W converter, reused by the painter-side tools.

Test Plan:
- Reset, then vsync 1 -> 0 and one 4-pixel line with H_DEC = V_DEC = 1, bytes F8,00 / 07,E0 / 00,1F / FF,FF, PIX_W = 8 -> writes at addr 0..3 with data E0, 1C, 03, FF.
- H_DEC = 4, V_DEC = 2, 640x4-byte lines -> 160 writes per kept line, rows 0 and 2 only; final wr_addr = 320.
- FB_DEPTH = 10, 16 kept pixels -> exactly 10 wr_en pulses, overflow = 1; next frame entry clears overflow to 0.
- vsync rises after 3 bytes of a line -> 1 write (pixel 0), frame_done pulses once, frame_count increments 0 -> 1.
- Frame 256 completes -> frame_count wraps to 0.
- rst pulsed mid-line -> outputs 0 in the same cycle; no writes until the next vsync high->low; with CAM_TEST_PATTERN_EN and test_mode = 1, first kept pixel data = white (PIX_W = 8: FF).
